dpi_mem_ctrl: RTL and testbench

- Parametrised, clocked successor to the combinational DPI memory port; serves one request at a time over valid/ready request and response channels.
- Backs physical memory through the DPI functions dpi_pmem_read(int) and dpi_pmem_write(int, int, byte).
- Adds a programmable access latency, multi-word data paths and misalignment error reporting.
- Sits between the core's LSU/IFU and the C-side pmem model.

---
 rtl/memctrl_pkg.sv | 36 +++
 rtl/memctrl_lfsr.sv | 22 ++
 rtl/dpi_mem_ctrl.sv | 129 ++++++++++++
 tb/tb_dpi_mem_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/memctrl_pkg.sv
// rtl/memctrl_pkg.sv - shared types, constants and the SV-side pmem model for dpi_mem_ctrl
// Optional random-delay feature selected by MEMCTRL_RAND_DELAY_EN.
package memctrl_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int BEAT_BYTES = 4;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic byte beat_mask(input logic [15:0] wmask, input int i);
    logic [15:0] sh;
    sh = wmask >> (4 * i);
    return byte'({4'b0000, sh[3:0]});
  endfunction

  // Stand-in for the C pmem model: a 4 KiB word window plus call counters
  localparam int PMEM_WORDS = 1024;
  logic [31:0] pmem [PMEM_WORDS];
  int unsigned pmem_rd_cnt;
  int unsigned pmem_wr_cnt;

  function automatic int dpi_pmem_read(input int addr);
    pmem_rd_cnt = pmem_rd_cnt + 1;
    return pmem[addr[11:2]];
  endfunction

  function automatic void dpi_pmem_write(input int addr, input int data, input byte mask);
    pmem_wr_cnt = pmem_wr_cnt + 1;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) pmem[addr[11:2]][8*b +: 8] = data[8*b +: 8];
    end
  endfunction

endpackage

// File: rtl/memctrl_lfsr.sv
// rtl/memctrl_lfsr.sv - 8-bit Fibonacci LFSR with enable for the random extra delay
// Present only when MEMCTRL_RAND_DELAY_EN is defined.
`ifdef MEMCTRL_RAND_DELAY_EN
module memctrl_lfsr
  import memctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= LFSR_SEED;
    end else if (en) begin
      value <= {value[6:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule
`endif

// File: rtl/dpi_mem_ctrl.sv
// rtl/dpi_mem_ctrl.sv - clocked single-outstanding memory port backed by dpi_pmem_read/write
// Optional random extra latency selected by MEMCTRL_RAND_DELAY_EN.
module dpi_mem_ctrl
  import memctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NBEAT = DATA_W / 32;
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CNT_W = 5;

  state_t state, state_nxt;

  logic                wen_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    delay;
  logic [1:0]          extra;

  logic                accept;
  logic                acc_en;
  logic                acc_wen;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [15:0]         acc_wmask;
  logic                misaligned;

`ifdef MEMCTRL_RAND_DELAY_EN
  logic [7:0] lfsr;

  memctrl_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .value (lfsr)
  );

  assign extra = lfsr[1:0];
`else
  assign extra = 2'd0;
`endif

  assign delay     = CNT_W'(LATENCY) + CNT_W'(extra);
  assign accept    = (state == IDLE) && req_valid;
  assign acc_en    = (accept && (delay == '0)) || ((state == WAIT) && (cnt == '0));

  // A zero-delay access uses the request as it arrives, since nothing is latched yet
  assign acc_wen   = (state == IDLE) ? req_wen   : wen_q;
  assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
  assign acc_wmask = (state == IDLE) ? 16'(req_wmask) : 16'(wmask_q);
  assign misaligned = (acc_addr[OFF_W-1:0] != '0);

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = (delay == '0) ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
        cnt     <= (delay == '0) ? '0 : delay - 1'b1;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (acc_en) begin
        if (misaligned) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end else begin
          rsp_err <= 1'b0;
          // Each beat reads before it writes so a write returns the old contents
          for (int i = 0; i < NBEAT; i++) begin
            rsp_rdata[32*i +: 32] <= dpi_pmem_read(32'(acc_addr) + 32'(BEAT_BYTES * i));
            if (acc_wen && (beat_mask(acc_wmask, i) != 8'h00)) begin
              dpi_pmem_write(32'(acc_addr) + 32'(BEAT_BYTES * i),
                             acc_wdata[32*i +: 32], beat_mask(acc_wmask, i));
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dpi_mem_ctrl.sv
// tb/tb_dpi_mem_ctrl.sv - self-checking bench for dpi_mem_ctrl (default build, MEMCTRL_RAND_DELAY_EN undefined)
module tb_dpi_mem_ctrl;
  import memctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_wen   [3];
  logic [31:0] req_addr  [3];
  logic [63:0] req_wdata [3];
  logic [7:0]  req_wmask [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic        rsp_err   [3];
  logic [31:0] rdata_a, rdata_c;
  logic [63:0] rdata_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // a: 32-bit/latency 1, b: 64-bit/latency 0, c: 32-bit/latency 4
  dpi_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0][31:0]),
    .req_wmask(req_wmask[0][3:0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rdata_a), .rsp_err(rsp_err[0]));

  dpi_mem_ctrl #(.ADDR_W(32), .DATA_W(64), .LATENCY(0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wmask(req_wmask[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rdata_b), .rsp_err(rsp_err[1]));

  dpi_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .LATENCY(4)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wen(req_wen[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2][31:0]),
    .req_wmask(req_wmask[2][3:0]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rdata_c), .rsp_err(rsp_err[2]));

  typedef struct {
    int          u;
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          lat;
    logic        chk_rdata;
    logic [63:0] rdata;
    logic        err;
    int          rd;
    int          wr;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [63:0] get_rdata(input int u);
    case (u)
      0:       return {32'h0, rdata_a};
      1:       return rdata_b;
      default: return {32'h0, rdata_c};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int u);
    int n;
    n = 0;
    while (!req_ready[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_req(input int u, input logic wen, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wmask,
                         output int lat, output logic [63:0] rdata, output logic err);
    @(negedge clk);
    req_valid[u] = 1'b1;
    req_wen[u]   = wen;
    req_addr[u]  = addr;
    req_wdata[u] = wdata;
    req_wmask[u] = wmask;
    wait_ready(u);
    @(posedge clk);
    @(negedge clk);
    req_valid[u] = 1'b0;
    lat = 1;
    while (!rsp_valid[u] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = get_rdata(u);
    err   = rsp_err[u];
    rsp_ready[u] = 1'b1;
    @(negedge clk);
    rsp_ready[u] = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [63:0] rd;
    logic        er;
    int          rd0, wr0;

    vecs[0]  = '{0, 1'b1, 32'h8000_0000, 64'hDEADBEEF, 8'h0F, 2, 1'b0, 64'h0, 1'b0, 1, 1};
    vecs[1]  = '{0, 1'b0, 32'h8000_0000, 64'h0, 8'h00, 2, 1'b1, 64'hDEADBEEF, 1'b0, 1, 0};
    vecs[2]  = '{0, 1'b1, 32'h8000_0000, 64'h0000CAFE, 8'h03, 2, 1'b1, 64'hDEADBEEF, 1'b0, 1, 1};
    vecs[3]  = '{0, 1'b0, 32'h8000_0000, 64'h0, 8'h00, 2, 1'b1, 64'hDEADCAFE, 1'b0, 1, 0};
    vecs[4]  = '{0, 1'b1, 32'h8000_0000, 64'hFFFFFFFF, 8'h00, 2, 1'b1, 64'hDEADCAFE, 1'b0, 1, 0};
    vecs[5]  = '{0, 1'b0, 32'h8000_0002, 64'h0, 8'h00, 2, 1'b1, 64'h0, 1'b1, 0, 0};
    vecs[6]  = '{1, 1'b1, 32'h8000_0008, 64'h11112222_33334444, 8'hFF, 1, 1'b0, 64'h0, 1'b0, 2, 2};
    vecs[7]  = '{1, 1'b0, 32'h8000_0008, 64'h0, 8'h00, 1, 1'b1, 64'h11112222_33334444, 1'b0, 2, 0};
    vecs[8]  = '{1, 1'b1, 32'h8000_0004, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 1, 1'b1, 64'h0, 1'b1, 0, 0};
    vecs[9]  = '{1, 1'b1, 32'h8000_0008, 64'hAAAABBBB_00000000, 8'hF0, 1, 1'b1, 64'h11112222_33334444, 1'b0, 2, 1};
    vecs[10] = '{1, 1'b0, 32'h8000_0008, 64'h0, 8'h00, 1, 1'b1, 64'hAAAABBBB_33334444, 1'b0, 2, 0};
    vecs[11] = '{0, 1'b0, 32'h8000_000C, 64'h0, 8'h00, 2, 1'b1, 64'hAAAABBBB, 1'b0, 1, 0};
    vecs[12] = '{2, 1'b0, 32'h8000_0000, 64'h0, 8'h00, 5, 1'b1, 64'hDEADCAFE, 1'b0, 1, 0};

    for (int u = 0; u < 3; u++) begin
      req_valid[u] = 1'b0; req_wen[u] = 1'b0; req_addr[u] = '0;
      req_wdata[u] = '0;   req_wmask[u] = '0; rsp_ready[u] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset_req_ready_%0d", u), 64'(req_ready[u]), 64'h1);
      chk($sformatf("reset_rsp_valid_%0d", u), 64'(rsp_valid[u]), 64'h0);
      chk($sformatf("reset_rdata_%0d", u), get_rdata(u), 64'h0);
      chk($sformatf("reset_err_%0d", u), 64'(rsp_err[u]), 64'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 13; v++) begin
      rd0 = pmem_rd_cnt;
      wr0 = pmem_wr_cnt;
      run_req(vecs[v].u, vecs[v].wen, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, lat, rd, er);
      chk($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].lat));
      if (vecs[v].chk_rdata) chk($sformatf("v%0d_rdata", v), rd, vecs[v].rdata);
      chk($sformatf("v%0d_err", v), 64'(er), 64'(vecs[v].err));
      chk($sformatf("v%0d_dpi_reads", v), 64'(pmem_rd_cnt - rd0), 64'(vecs[v].rd));
      chk($sformatf("v%0d_dpi_writes", v), 64'(pmem_wr_cnt - wr0), 64'(vecs[v].wr));
    end

    // Response stall with a competing write held on the request channel
    rd0 = pmem_rd_cnt;
    wr0 = pmem_wr_cnt;
    @(negedge clk);
    req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 32'h8000_0000; req_wmask[0] = 8'h00;
    wait_ready(0);
    @(posedge clk);
    @(negedge clk);
    req_wen[0] = 1'b1; req_wdata[0] = 64'h0; req_wmask[0] = 8'h0F;
    lat = 1;
    while (!rsp_valid[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("stall_latency", 64'(lat), 64'd2);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_rsp_valid", k), 64'(rsp_valid[0]), 64'h1);
      chk($sformatf("stall%0d_rdata", k), {32'h0, rdata_a}, 64'hDEADCAFE);
      chk($sformatf("stall%0d_req_ready", k), 64'(req_ready[0]), 64'h0);
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    chk("stall_dpi_reads", 64'(pmem_rd_cnt - rd0), 64'd1);
    chk("stall_dpi_writes", 64'(pmem_wr_cnt - wr0), 64'd0);
    chk("stall_after_rdata", {32'h0, rdata_a}, 64'hDEADCAFE);
    chk("stall_back_idle", 64'(req_ready[0]), 64'h1);

    // Reset during WAIT of a latency-4 write
    wr0 = pmem_wr_cnt;
    @(negedge clk);
    req_valid[2] = 1'b1; req_wen[2] = 1'b1; req_addr[2] = 32'h8000_0010;
    req_wdata[2] = 64'h12345678; req_wmask[2] = 8'h0F;
    wait_ready(2);
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("wait_req_ready", 64'(req_ready[2]), 64'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req_ready", 64'(req_ready[2]), 64'h1);
    chk("async_rsp_valid", 64'(rsp_valid[2]), 64'h0);
    chk("async_rdata_c", {32'h0, rdata_c}, 64'h0);
    chk("async_rdata_a", {32'h0, rdata_a}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_no_write", 64'(pmem_wr_cnt - wr0), 64'd0);
    chk("rst_req_ready", 64'(req_ready[2]), 64'h1);
    chk("rst_rsp_valid", 64'(rsp_valid[2]), 64'h0);

    run_req(2, 1'b0, 32'h8000_0000, 64'h0, 8'h00, lat, rd, er);
    chk("post_rst_latency", 64'(lat), 64'd5);
    chk("post_rst_rdata", rd, 64'hDEADCAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
